ecall_console: RTL and testbench
================================

// Module: ecall_console
// PURPOSE
// - Services ecall instructions flagged by the decode/regfile stage, using the a0/a1/a2 register values.
// - Service select: a0==0 && a1==0 -> stop; a0==0 && a1==1 -> print a2 as hex plus newline;
//   a0==0 && a1==2 -> print a2[7:0] as one raw char; anything else -> no-op.
// - Holds the pipeline with stall while bytes drain over a valid/ready byte stream to the console sink.
// - Raises a sticky halt for stop.
// PARAMETERS
// - HEX_LOWER   1  1: hex digits a-f are 0x61-0x66; 0: A-F are 0x41-0x46
// - APPEND_NL   1  1: hex print ends with 0x0A (9 bytes total); 0: 8 bytes, no newline
// PORTS
// - clk        in   1   single clock; all state updates on posedge
// - reset      in   1   synchronous, active-high; sampled on posedge clk
// - ecall_sig  in   1   level; high while an ecall sits in the servicing stage, held while stall=1
// - reg_a0     in   32  x10 read value
// - reg_a1     in   32  x11 read value
// - reg_a2     in   32  x12 read value
// - tx_ready   in   1   console sink accepts tx_data this cycle
// - tx_valid   out  1   tx_data holds a valid byte
// - tx_data    out  8   output character
// - stall      out  1   freeze the ecall stage and all stages upstream of it
// - halt       out  1   sticky stop indication
// BEHAVIOUR
// - Reset values: state=IDLE, halt=0, tx_valid=0, tx_data=0, stall=0, counter=0.
// - While reset=1, stall is forced 0.
// - States:
//   - IDLE: wait for an ecall.
//   - SEND: drain bytes to the console.
//   - DONE: release stall for exactly one cycle.
//   - HALTED: terminal until reset.
// - IDLE with ecall_sig=1, decoded from reg_a0/reg_a1 that same cycle:
//   - stop: go to HALTED; halt=1 from the next cycle.
//   - print (hex or char): stall=1 combinationally in this same cycle; latch reg_a2 and the mode; counter=0; go to SEND.
//   - no-op: stay in IDLE; stall=0; the instruction retires with no effect.
// - SEND:
//   - stall=1 and tx_valid=1.
//   - tx_data is registered and stable while tx_valid && !tx_ready.
//   - A byte transfers on any cycle where tx_valid && tx_ready. On each transfer, counter increments and tx_data loads the next byte.
//   - Hex mode byte k (k=0..7) = ASCII of latched a2[31-4k -: 4]: 0-9 -> 0x30-0x39, 10-15 per HEX_LOWER.
//   - Hex mode with APPEND_NL=1: byte 8 = 0x0A.
//   - Char mode: single byte = latched a2[7:0].
//   - Transfer of the last byte -> DONE; tx_valid=0 from the next cycle.
// - DONE:
//   - stall=0 so the ecall leaves the stage. ecall_sig is ignored this cycle because it is the same instruction.
//   - Next cycle -> IDLE. Back-to-back ecalls are therefore serviced separately.
// - HALTED: stall=1, halt=1, tx_valid=0. Left only by reset.
// - tx_ready while tx_valid=0 is ignored. tx_ready may stay low indefinitely; the block then waits with no timeout.
// - Reset in mid-SEND: on that edge the block returns to the reset values, the partial message is abandoned, and no further bytes are sent.
// - Register values are sampled only in IDLE. Changes to reg_a* during SEND have no effect.
// - Latency: with tx_ready held at 1, a hex print stalls 1 + 9 cycles (APPEND_NL=1). Char print stalls 2 cycles.
// TESTING
// - a0=0,a1=1,a2=0x1234ABCD, tx_ready=1 -> bytes 31 32 33 34 61 62 63 64 0A; stall high 10 cycles; then one DONE cycle; halt=0.
// - Same print with tx_ready toggling 1,0,0,1,... -> identical byte sequence; tx_data stable during every !tx_ready cycle; no byte lost or duplicated.
// - a0=0,a1=2,a2=0x00000041 -> single byte 0x41, then DONE, then IDLE; a second ecall right after DONE -> serviced again.
// - a0=0,a1=0 -> halt=1 next cycle and stays 1 with stall=1 until reset; reset -> halt=0, stall=0.
// - a0=5,a1=1 -> no stall, no tx_valid, no halt; the ecall passes in 1 cycle.
// - Reset asserted after byte 3 of a hex print -> tx_valid=0, stall=0 after the edge; no further bytes appear.

Source files
------------

// File: rtl/ecall_console.sv
// Console service for ecall instructions: decodes a0/a1, streams a2 as hex or a raw
// character over a valid/ready byte stream, and raises a sticky halt on stop.
module ecall_console #(
  parameter bit HEX_LOWER = 1'b1,
  parameter bit APPEND_NL = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ecall_sig,
  input  logic [31:0] reg_a0,
  input  logic [31:0] reg_a1,
  input  logic [31:0] reg_a2,
  input  logic        tx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  output logic        stall,
  output logic        halt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND   = 2'd1,
    DONE   = 2'd2,
    HALTED = 2'd3
  } state_t;

  localparam logic [3:0] LAST_HEX = APPEND_NL ? 4'd8 : 4'd7;

  state_t      state;
  logic [31:0] a2_q;
  logic        hex_mode;
  logic [3:0]  counter;

  logic       is_svc;
  logic       is_stop;
  logic       is_hex;
  logic       is_char;
  logic [3:0] next_idx;
  logic       last_byte;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    if (n < 4'd10)  return 8'h30 + {4'h0, n};
    else if (HEX_LOWER) return 8'h57 + {4'h0, n};
    else            return 8'h37 + {4'h0, n};
  endfunction

  // Byte k of a hex message: nibbles MSB first, index 8 is the trailing newline.
  function automatic logic [7:0] hex_byte(input logic [31:0] v, input logic [3:0] k);
    logic [31:0] sh;
    sh = v << {k[2:0], 2'b00};
    if (k == 4'd8) return 8'h0A;
    return hex_char(sh[31:28]);
  endfunction

  assign is_svc    = (reg_a0 == 32'd0);
  assign is_stop   = is_svc && (reg_a1 == 32'd0);
  assign is_hex    = is_svc && (reg_a1 == 32'd1);
  assign is_char   = is_svc && (reg_a1 == 32'd2);
  assign next_idx  = counter + 4'd1;
  assign last_byte = !hex_mode || (counter == LAST_HEX);

  // Stall must rise in the same cycle a print is accepted so the ecall stays put.
  assign stall = !reset && ((state == SEND) || (state == HALTED) ||
                 ((state == IDLE) && ecall_sig && (is_hex || is_char)));

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      halt     <= 1'b0;
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
      counter  <= 4'd0;
      a2_q     <= 32'd0;
      hex_mode <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ecall_sig) begin
            if (is_stop) begin
              state <= HALTED;
              halt  <= 1'b1;
            end else if (is_hex || is_char) begin
              a2_q     <= reg_a2;
              hex_mode <= is_hex;
              counter  <= 4'd0;
              tx_valid <= 1'b1;
              tx_data  <= is_hex ? hex_byte(reg_a2, 4'd0) : reg_a2[7:0];
              state    <= SEND;
            end
          end
        end
        SEND: begin
          if (tx_ready) begin
            counter <= next_idx;
            if (last_byte) begin
              tx_valid <= 1'b0;
              state    <= DONE;
            end else begin
              tx_data <= hex_byte(a2_q, next_idx);
            end
          end
        end
        // Same instruction is still in the stage; let it leave before decoding again.
        DONE:    state <= IDLE;
        HALTED:  state <= HALTED;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ecall_console.sv
// Directed bench for ecall_console: hex/char prints under back-pressure, stop, no-op,
// and reset in the middle of a message.
module tb_ecall_console;

  logic        clk = 1'b0;
  logic        reset;
  logic        ecall_sig;
  logic [31:0] reg_a0, reg_a1, reg_a2;
  logic        tx_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        stall;
  logic        halt;

  int passed = 0;
  int total  = 0;

  logic [7:0] exp_b [9];
  int         exp_n;
  logic [7:0] got_b [$];
  int         stall_cycles;

  ecall_console #(.HEX_LOWER(1'b1), .APPEND_NL(1'b1)) dut (
    .clk      (clk),
    .reset    (reset),
    .ecall_sig(ecall_sig),
    .reg_a0   (reg_a0),
    .reg_a1   (reg_a1),
    .reg_a2   (reg_a2),
    .tx_ready (tx_ready),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .stall    (stall),
    .halt     (halt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Runs one print from the IDLE cycle until stall drops; mode 0 = ready always, 1 = 1,0,0 repeating.
  task automatic run_print(input string tag, input int mode, input logic scramble);
    logic       held;
    logic [7:0] held_d;
    int         i;
    held = 1'b0;
    held_d = 8'h00;
    stall_cycles = 0;
    got_b.delete();
    i = 0;
    while (stall && i < 100) begin
      if (held) begin
        check({tag, " hold_valid"}, 32'(tx_valid), 32'd1);
        check({tag, " hold_data"}, 32'(tx_data), 32'(held_d));
      end
      tx_ready = (mode == 0) ? 1'b1 : ((i % 3) == 0);
      stall_cycles++;
      held = 1'b0;
      if (tx_valid) begin
        if (tx_ready) got_b.push_back(tx_data);
        else begin
          held = 1'b1;
          held_d = tx_data;
        end
      end
      step();
      if (scramble && i == 0) reg_a2 = ~reg_a2;
      i++;
    end
    check({tag, " terminated"}, 32'(stall), 32'd0);
    check({tag, " byte_count"}, 32'(got_b.size()), 32'(exp_n));
    for (int k = 0; k < exp_n && k < got_b.size(); k++)
      check($sformatf("%s byte%0d", tag, k), 32'(got_b[k]), 32'(exp_b[k]));
    check({tag, " done_valid"}, 32'(tx_valid), 32'd0);
    check({tag, " done_halt"}, 32'(halt), 32'd0);
  endtask

  task automatic load_hex_exp();
    exp_b = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h61, 8'h62, 8'h63, 8'h64, 8'h0A};
    exp_n = 9;
  endtask

  initial begin
    reset = 1'b1; ecall_sig = 1'b0; tx_ready = 1'b0;
    reg_a0 = 32'd0; reg_a1 = 32'd0; reg_a2 = 32'd0;
    @(negedge clk);
    step();
    check("rst tx_valid", 32'(tx_valid), 32'd0);
    check("rst tx_data", 32'(tx_data), 32'd0);
    check("rst stall", 32'(stall), 32'd0);
    check("rst halt", 32'(halt), 32'd0);
    // Stall is held low during reset even with a print request present.
    ecall_sig = 1'b1; reg_a1 = 32'd1; #1;
    check("rst stall_forced", 32'(stall), 32'd0);
    step();
    check("rst no_send", 32'(tx_valid), 32'd0);

    // Hex print, sink always ready.
    reset = 1'b0; reg_a0 = 32'd0; reg_a1 = 32'd1; reg_a2 = 32'h1234ABCD; tx_ready = 1'b1;
    #1;
    check("hex idle_stall", 32'(stall), 32'd1);
    check("hex idle_valid", 32'(tx_valid), 32'd0);
    load_hex_exp();
    run_print("hex", 0, 1'b0);
    check("hex stall_cycles", 32'(stall_cycles), 32'd10);
    ecall_sig = 1'b0;
    step();
    check("hex idle_after", 32'(stall), 32'd0);
    check("hex idle_after_v", 32'(tx_valid), 32'd0);

    // Same print with back-pressure; a2 scrambled mid-message must not matter.
    ecall_sig = 1'b1; reg_a2 = 32'h1234ABCD; #1;
    run_print("hexbp", 1, 1'b1);
    ecall_sig = 1'b0;
    step();

    // Char print, then a second ecall immediately after DONE.
    ecall_sig = 1'b1; reg_a1 = 32'd2; reg_a2 = 32'h00000041; #1;
    exp_b[0] = 8'h41; exp_n = 1;
    run_print("chr1", 0, 1'b0);
    check("chr1 stall_cycles", 32'(stall_cycles), 32'd2);
    reg_a2 = 32'h00000042;
    step();
    check("chr2 idle_stall", 32'(stall), 32'd1);
    exp_b[0] = 8'h42;
    run_print("chr2", 0, 1'b0);
    check("chr2 stall_cycles", 32'(stall_cycles), 32'd2);
    ecall_sig = 1'b0;
    step();

    // No-op service.
    ecall_sig = 1'b1; reg_a0 = 32'd5; reg_a1 = 32'd1; #1;
    check("nop stall", 32'(stall), 32'd0);
    step();
    check("nop valid", 32'(tx_valid), 32'd0);
    check("nop halt", 32'(halt), 32'd0);
    check("nop stall2", 32'(stall), 32'd0);
    ecall_sig = 1'b0;
    step();

    // Stop: sticky halt until reset.
    ecall_sig = 1'b1; reg_a0 = 32'd0; reg_a1 = 32'd0; #1;
    check("stop pre_halt", 32'(halt), 32'd0);
    step();
    check("stop halt", 32'(halt), 32'd1);
    check("stop stall", 32'(stall), 32'd1);
    check("stop valid", 32'(tx_valid), 32'd0);
    ecall_sig = 1'b0;
    repeat (3) step();
    check("stop halt_sticky", 32'(halt), 32'd1);
    check("stop stall_sticky", 32'(stall), 32'd1);
    reset = 1'b1;
    step();
    check("stop rst_halt", 32'(halt), 32'd0);
    check("stop rst_stall", 32'(stall), 32'd0);
    reset = 1'b0;
    step();

    // Reset in the middle of a hex print.
    ecall_sig = 1'b1; reg_a0 = 32'd0; reg_a1 = 32'd1; reg_a2 = 32'h1234ABCD; tx_ready = 1'b1;
    repeat (4) step();
    check("mid byte3", 32'(tx_data), 32'h34);
    check("mid valid", 32'(tx_valid), 32'd1);
    reset = 1'b1; ecall_sig = 1'b0;
    step();
    check("mid rst_valid", 32'(tx_valid), 32'd0);
    check("mid rst_stall", 32'(stall), 32'd0);
    check("mid rst_data", 32'(tx_data), 32'd0);
    reset = 1'b0;
    repeat (3) begin
      step();
      check("mid no_more", 32'(tx_valid), 32'd0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
